// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle of the hazard unit
interface hazard_ctrl_if;
  // ID / EX operand and destination addresses
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [2:0] MemReadE;
  logic       PCSrcE;

  // multi-cycle engine handshake
  logic       MdOpE;
  logic       MdDone;
  logic       MdStart;
  logic       MdErr;

  // write-back info from MEM and WB
  logic       RegWriteM;
  logic [4:0] RdM;
  logic       RegWriteW;
  logic [4:0] RdW;

  // pipeline control
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;

  // pipeline side: drives stage info, consumes control
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, PCSrcE,
    output MdOpE, MdDone, RegWriteM, RdM, RegWriteW, RdW,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, MdStart, MdErr
  );

  // hazard unit side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, PCSrcE,
    input  MdOpE, MdDone, RegWriteM, RdM, RegWriteW, RdW,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, MdStart, MdErr
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use stall, branch flush and mul/div sequencing
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  // counter is wide enough to hold MD_TIMEOUT itself (one increment past the last BUSY cycle)
  localparam int CW = $clog2(MD_TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          md_busy;
  logic          md_start;
  logic          load_use;

  // MEM result wins over WB result; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wm,
    input logic [4:0] rdm,
    input logic       ww,
    input logic [4:0] rdw
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wm && (rdm != 5'd0) && (rdm == rs)) begin
      sel = 2'b10;
    end else if (ww && (rdw != 5'd0) && (rdw == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // state, busy counter and sticky error; reset returns to IDLE at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // multi-cycle sequencing: launch once, wait for done or timeout, release for one cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    md_start = 1'b0;
    md_busy  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hz.MdOpE) begin
          md_start = 1'b1;
          md_busy  = 1'b1;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        md_busy = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (hz.MdDone) begin
          // a completion in the timeout cycle still counts as success
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        // no stall here, so the EX op advances exactly once
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // load in EX whose destination is read by the instruction in ID
  always_comb begin
    load_use = (hz.MemReadE != 3'd0) && (hz.RdE != 5'd0) &&
               ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  end

  // pipeline control; a stalled EX register must not also be flushed
  always_comb begin
    hz.StallF    = load_use | md_busy;
    hz.StallD    = load_use | md_busy;
    hz.StallE    = md_busy;
    hz.FlushM    = md_busy;
    hz.FlushD    = hz.PCSrcE & ~md_busy;
    hz.FlushE    = (load_use | hz.PCSrcE) & ~md_busy;
    hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    hz.MdStart   = md_start;
    hz.MdErr     = err_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model of the multi-cycle op, by transaction phase
  bit   m_launched;
  bit   m_release;
  int   m_elapsed;
  bit   m_err;

  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MD_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    bit from_mem, from_wb;
    from_mem = hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs;
    from_wb  = hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs;
    return from_mem ? 2'd2 : (from_wb ? 2'd1 : 2'd0);
  endfunction

  task automatic model_reset();
    m_launched = 0;
    m_release  = 0;
    m_elapsed  = 0;
    m_err      = 0;
  endtask

  task automatic check_all();
    bit lu, start, busy;
    lu    = hz.MemReadE != 0 && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    start = !m_launched && !m_release && hz.MdOpE;
    busy  = start || m_launched;
    chk("stall_f", hz.StallF, lu || busy);
    chk("stall_d", hz.StallD, lu || busy);
    chk("stall_e", hz.StallE, busy);
    chk("flush_m", hz.FlushM, busy);
    chk("flush_d", hz.FlushD, hz.PCSrcE && !busy);
    chk("flush_e", hz.FlushE, (lu || hz.PCSrcE) && !busy);
    chk("fwd_a", hz.ForwardAE, ref_fwd(hz.Rs1E));
    chk("fwd_b", hz.ForwardBE, ref_fwd(hz.Rs2E));
    chk("md_start", hz.MdStart, start);
    chk("md_err", hz.MdErr, m_err);
  endtask

  task automatic model_clock();
    if (rst) begin
      model_reset();
    end else if (m_release) begin
      m_release = 0;
    end else if (m_launched) begin
      m_elapsed++;
      if (hz.MdDone) begin
        m_launched = 0;
        m_release  = 1;
      end else if (m_elapsed == TO) begin
        m_launched = 0;
        m_release  = 1;
        m_err      = 1;
      end
    end else if (hz.MdOpE) begin
      m_launched = 1;
      m_elapsed  = 0;
    end
  endtask

  // called at a falling edge with inputs already applied
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
    hz.MemReadE = 0; hz.PCSrcE = 0; hz.MdOpE = 0; hz.MdDone = 0;
    hz.RegWriteM = 0; hz.RdM = 0; hz.RegWriteW = 0; hz.RdW = 0;
  endtask

  // bring the op sequencer back to idle without a timeout
  task automatic settle();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      if (!m_launched && !m_release) break;
      hz.MdDone = m_launched;
      tick();
    end
    hz.MdDone = 0;
    chk("settle_idle", {m_launched, m_release}, 2'b00);
  endtask

  initial begin
    int stall_cnt, start_cnt, guard;

    clear_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_all();
    chk("rst_stall_e", hz.StallE, 1'b0);
    chk("rst_md_err", hz.MdErr, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // forwarding priority
    hz.RegWriteM = 1; hz.RdM = 5; hz.RegWriteW = 1; hz.RdW = 5; hz.Rs1E = 5;
    #1 chk("fwd_mem_prio", hz.ForwardAE, 2'b10);
    tick();
    hz.RegWriteM = 0;
    #1 chk("fwd_wb", hz.ForwardAE, 2'b01);
    tick();
    hz.RdM = 0; hz.RdW = 0; hz.Rs1E = 0; hz.RegWriteM = 1;
    #1 chk("fwd_x0", hz.ForwardAE, 2'b00);
    tick();
    clear_inputs();

    // load-use
    hz.MemReadE = 3'b010; hz.RdE = 7; hz.Rs2D = 7;
    #1;
    chk("lu_stall_f", hz.StallF, 1); chk("lu_stall_d", hz.StallD, 1);
    chk("lu_flush_e", hz.FlushE, 1); chk("lu_flush_d", hz.FlushD, 0);
    tick();
    clear_inputs();
    #1 chk("lu_released", hz.StallF, 0);
    tick();

    // taken branch
    hz.PCSrcE = 1;
    #1;
    chk("br_flush_d", hz.FlushD, 1); chk("br_flush_e", hz.FlushE, 1);
    chk("br_stall_f", hz.StallF, 0);
    tick();
    clear_inputs();

    // multi-cycle op, done 5 cycles after launch, then back-to-back launch
    stall_cnt = 0; start_cnt = 0;
    hz.MdOpE = 1;
    for (int c = 0; c < 7; c++) begin
      hz.MdDone = (c == 5);
      hz.MdOpE  = (c != 6);
      #1;
      stall_cnt += hz.StallE;
      start_cnt += hz.MdStart;
      if (c == 6) chk("md_done_no_stall", {hz.StallE, hz.FlushM}, 2'b00);
      tick();
    end
    chk("md_stall_cycles", stall_cnt, 6);
    chk("md_start_cycles", start_cnt, 1);
    hz.MdDone = 0; hz.MdOpE = 1;
    #1 chk("md_b2b_start", hz.MdStart, 1);
    tick();
    settle();

    // done exactly in the timeout cycle is success
    hz.MdOpE = 1;
    tick();
    hz.MdOpE = 0;
    for (int c = 1; c <= TO; c++) begin
      hz.MdDone = (c == TO);
      tick();
    end
    hz.MdDone = 0;
    #1 chk("to_edge_no_err", hz.MdErr, 0);
    tick();

    // real timeout
    hz.MdOpE = 1;
    stall_cnt = 0; guard = 0;
    #1;
    while (hz.StallE && guard < 3 * TO) begin
      stall_cnt++;
      guard++;
      tick();
      hz.MdOpE = 0;
      #1;
    end
    chk("to_bound", guard < 3 * TO, 1);
    chk("to_stall_cycles", stall_cnt, TO + 1);
    chk("to_err_set", hz.MdErr, 1);
    tick();
    hz.MdOpE = 1;
    tick();
    settle();
    #1 chk("to_err_sticky", hz.MdErr, 1);

    // async reset on the 3rd BUSY cycle
    hz.MdOpE = 1;
    tick();
    hz.MdOpE = 0;
    tick();
    tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_stall_f", hz.StallF, 0); chk("arst_stall_e", hz.StallE, 0);
    chk("arst_flush_m", hz.FlushM, 0); chk("arst_err", hz.MdErr, 0);
    @(negedge clk);
    rst = 1'b0;
    hz.MdDone = 1;
    tick();
    hz.MdDone = 0;
    #1 chk("arst_done_ignored", hz.StallE, 0);
    tick();
    hz.MdOpE = 1;
    #1 chk("arst_relaunch", hz.MdStart, 1);
    tick();
    settle();

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      hz.Rs1D = 5'($urandom_range(0, 3));
      hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3));
      hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE  = 5'($urandom_range(0, 3));
      hz.RdM  = 5'($urandom_range(0, 3));
      hz.RdW  = 5'($urandom_range(0, 3));
      hz.MemReadE  = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      hz.RegWriteM = 1'($urandom);
      hz.RegWriteW = 1'($urandom);
      hz.PCSrcE    = ($urandom_range(0, 3) == 0);
      hz.MdOpE     = ($urandom_range(0, 2) == 0);
      hz.MdDone    = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64, meaning maximum BUSY cycles before a multi-cycle op is abandoned.
REQ-002 clk  in  1  clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 Rs1D, Rs2D  in  5 each  source register addresses of the instruction in ID.
REQ-005 Rs1E, Rs2E, RdE  in  5 each  source and destination addresses in EX; RdE is 0 after a flush.
REQ-006 MemReadE  in  3  load type in EX; nonzero means the EX instruction is a load.
REQ-007 PCSrcE  in  1  taken branch or jump resolved in EX.
REQ-008 MdOpE  in  1  EX holds a multi-cycle (mul/div) op.
REQ-009 MdDone  in  1  multi-cycle engine result valid, single-cycle pulse.
REQ-010 RegWriteM, RdM[4:0], RegWriteW, RdW[4:0]  in  write-back info of the MEM and WB stages.
REQ-011 StallF, StallD, StallE  out  1 each  hold the IF, ID and EX pipeline registers.
REQ-012 FlushD, FlushE, FlushM  out  1 each  insert a bubble into the IF/ID, ID/EX and EX/MEM registers.
REQ-013 ForwardAE, ForwardBE  out  2 each  EX operand source: 00 register file, 01 WB result, 10 MEM ALU result.
REQ-014 MdStart  out  1  one-cycle launch pulse to the multi-cycle engine.
REQ-015 MdErr  out  1  sticky timeout flag.

Function
REQ-016 ForwardAE SHALL be 10 when RegWriteM, RdM!=0 and RdM==Rs1E; otherwise 01 when RegWriteW, RdW!=0 and RdW==Rs1E; otherwise 00. MEM has priority over WB.
REQ-017 ForwardBE SHALL follow the same rule as REQ-016, with Rs2E in place of Rs1E.
REQ-018 Forwarding SHALL be combinational, with zero-cycle latency.
REQ-019 LoadUse SHALL be true when MemReadE!=0, RdE!=0, and (RdE==Rs1D or RdE==Rs2D).
REQ-020 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-021 In IDLE with MdOpE=1, MdStart SHALL be 1; in any other state MdStart SHALL be 0.
REQ-022 FSM transitions SHALL be:
- IDLE -> BUSY on MdOpE.
- BUSY -> DONE on MdDone.
- BUSY -> DONE on timeout.
- DONE -> IDLE unconditionally.
REQ-023 MdDone SHALL be ignored in IDLE and in DONE.
REQ-024 MdBusy SHALL be (IDLE and MdOpE) or BUSY; DONE SHALL NOT stall, so the op advances exactly once.
REQ-025 StallF and StallD SHALL equal LoadUse or MdBusy.
REQ-026 StallE and FlushM SHALL equal MdBusy.
REQ-027 FlushD SHALL equal PCSrcE and not MdBusy.
REQ-028 FlushE SHALL equal (LoadUse or PCSrcE) and not MdBusy; stall of EX wins over flush of EX.
REQ-029 The busy counter SHALL clear on entry to BUSY and increment on each BUSY cycle.
REQ-030 When the busy counter reaches MD_TIMEOUT-1 without MdDone, the FSM SHALL go to DONE and set MdErr.
REQ-031 MdDone arriving in the same cycle as the timeout SHALL count as completion; MdErr SHALL NOT be set in that case.
REQ-032 MdErr SHALL remain set until reset.
REQ-033 Back-to-back multi-cycle ops SHALL be handled as follows: after DONE -> IDLE, a new MdOpE SHALL start a new MdStart pulse; no op SHALL ever be launched twice.
REQ-034 All outputs other than MdErr SHALL be combinational from the current state and inputs.
REQ-035 The FSM state, the busy counter and MdErr SHALL be the only registered state.

Reset
REQ-036 While rst is high, the FSM SHALL be in IDLE, the counter SHALL be 0 and MdErr SHALL be 0.
REQ-037 Reset asserted in BUSY SHALL return the FSM to IDLE immediately (asynchronously); a MdDone arriving later SHALL be ignored.
REQ-038 Outputs SHALL follow REQ-016 to REQ-028 evaluated in IDLE; with all inputs 0, every output SHALL be 0.

Verification
REQ-039 Forwarding priority: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 -> ForwardAE=10; drop RegWriteM -> ForwardAE=01; set RdM=RdW=0 with Rs1E=0 -> ForwardAE=00.
REQ-040 Load-use: MemReadE=3'b010, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; FlushD=0.
REQ-041 Branch taken: PCSrcE=1, no LoadUse -> FlushD=FlushE=1 and StallF=0 in the same cycle.
REQ-042 Multi-cycle op: MdOpE held at 1, MdDone pulsed 5 cycles after MdStart -> MdStart high for exactly 1 cycle; StallE and FlushM high for 6 cycles; 0 in DONE; state back to IDLE after 7 cycles.
REQ-043 Timeout: MdOpE=1 with no MdDone, MD_TIMEOUT=8 -> FSM reaches DONE after 8 BUSY cycles and MdErr=1; MdErr stays 1 through later ops until rst.
REQ-044 Reset in BUSY: assert rst on the 3rd BUSY cycle -> all stall outputs drop asynchronously and MdErr=0; a MdDone pulse after reset release -> no FSM change.
